prob_3_34_sweeper: RTL and testbench
====================================

PROB_3_34_SWEEPER -- requirements
Module: prob_3_34_sweeper

Interface
REQ-001 Parameter SETTLE, default 1, meaning: cycles each vector is held on A..D before the DUT outputs are sampled; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle request to run a full sweep; honoured only in IDLE.
REQ-005 A, B, C, D  output  1 each  stimulus to the 4-input/3-output function under test; {A,B,C,D} = vec[3:0].
REQ-006 Out_1, Out_2, Out_3  input  1 each  DUT responses.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse at sweep end.
REQ-009 pass  output  1  result of the last completed sweep: 1 = zero mismatches.
REQ-010 err_count  output  5  number of mismatching vectors in the current or last sweep (0..16).
REQ-011 first_fail_vec  output  4  vec of the first mismatch.
REQ-012 first_fail_obs  output  3  observed {Out_1,Out_2,Out_3} at the first mismatch.

Function
REQ-013 Golden model: E1 = (A|~B)&~C&(C|D); E2 = ((~C&D)|(B&C&D)|(C&~D))&(~A|B); E3 = (((A&B)|C)&D)|(~B&C).
REQ-014 FSM states: IDLE, SETTLE, CHECK, DONE.
REQ-015 IDLE & start=1 -> SETTLE; vec<=0, wait_cnt<=0, err_count<=0, pass<=0, first_fail_vec<=0, first_fail_obs<=0.
REQ-016 SETTLE: wait_cnt increments each cycle; when wait_cnt==SETTLE-1 -> CHECK.
REQ-017 A..D equal vec and are stable throughout SETTLE and CHECK; they change only on the CHECK->SETTLE transition.
REQ-018 CHECK: compare {Out_1,Out_2,Out_3} with {E1,E2,E3} of vec; on mismatch err_count increments by 1.
REQ-019 First-fail capture: on a mismatch with err_count==0, load first_fail_vec<=vec and first_fail_obs<=observed; later mismatches do not overwrite these.
REQ-020 CHECK with vec==15 -> DONE; otherwise vec<=vec+1, wait_cnt<=0 -> SETTLE. vec does not wrap within a sweep.
REQ-021 DONE: done=1 for exactly that cycle; pass<=(err_count==0), using the count including the vec-15 result; then -> IDLE.
REQ-022 Latency: done is high exactly 16*(SETTLE+1)+1 cycles after the cycle in which start is sampled high (33 for SETTLE=1).
REQ-023 start while busy=1 is ignored, with no effect on the sweep.
REQ-024 err_count, pass, first_fail_vec and first_fail_obs hold their values in IDLE until the next accepted start.
REQ-025 err_count cannot exceed 16; no saturation logic is needed.

Reset
REQ-026 rst=1 at a clock edge forces IDLE, vec=0, wait_cnt=0, A..D=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_obs=0.
REQ-027 Reset has priority over start and over any state, including mid-sweep; an aborted sweep produces no done pulse.

Structure
REQ-028 The state encoding (2-bit localparams) and the vector count constant (16) live in a shared package/include, prob_3_34_pkg.
REQ-029 The golden equations form one combinational sub-module, prob_3_34_golden (inputs A,B,C,D; outputs E1,E2,E3), instantiated once and reusable by benches.
REQ-030 All state, counters and outputs are registered on clk; the only combinational path is golden-model-to-compare.

Verification
REQ-031 Correct DUT, SETTLE=1, start pulse -> done at +33 cycles, pass=1, err_count=0, first_fail_vec=0, first_fail_obs=0.
REQ-032 Golden spot-checks during the sweep -> vec 0 expects 000, vec 1 expects 110, vec 10 expects 001, vec 15 expects 011 ({E1,E2,E3}).
REQ-033 DUT with Out_1 stuck-at-0 -> err_count=3 (vecs 1, 9, 13), first_fail_vec=1, first_fail_obs=3'b010, pass=0.
REQ-034 SETTLE=3; start re-pulsed while busy -> single done at +65 cycles; A..D observed constant for 4 cycles per vector.
REQ-035 rst asserted during vec 7 CHECK -> next cycle IDLE, busy=0, err_count=0, no done; a subsequent start runs a full clean sweep.
REQ-036 Out_3 inverted DUT -> err_count=16, first_fail_vec=0, first_fail_obs=3'b001, pass=0; results held until next start.

Source files
------------

// File: rtl/prob_3_34_pkg.sv
// Shared constants for the 4-in/3-out function sweeper: FSM encoding and sweep length.
// Combinational constants only; no latency, no backpressure.
package prob_3_34_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_CHECK  = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    localparam int         VEC_COUNT = 16;
    localparam logic [3:0] VEC_LAST  = 4'(VEC_COUNT - 1);

endpackage

// File: rtl/prob_3_34_golden.sv
// Golden model of the 4-input/3-output function under test.
// Purely combinational, zero latency, no backpressure.
module prob_3_34_golden (
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic E1,
    output logic E2,
    output logic E3
);

    assign E1 = (A | ~B) & ~C & (C | D);
    assign E2 = ((~C & D) | (B & C & D) | (C & ~D)) & (~A | B);
    assign E3 = (((A & B) | C) & D) | (~B & C);

endmodule

// File: rtl/prob_3_34_sweeper.sv
// Exhaustive sweeper: drives all 16 vectors, compares DUT responses to the golden model.
// done fires 16*(SETTLE+1)+1 cycles after an accepted start; start is ignored while busy.
module prob_3_34_sweeper
    import prob_3_34_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    input  logic       Out_1,
    input  logic       Out_2,
    input  logic       Out_3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail_vec,
    output logic [2:0] first_fail_obs
);

    state_t     r_state;
    logic [3:0] r_vec;
    logic [3:0] r_wait;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [4:0] r_err;
    logic [3:0] r_ffv;
    logic [2:0] r_ffo;

    state_t     w_next_state;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic       w_e1, w_e2, w_e3;
    logic [2:0] w_obs;
    logic       w_mismatch;
    logic       w_settled;

    prob_3_34_golden u_golden (
        .A  (r_vec[3]),
        .B  (r_vec[2]),
        .C  (r_vec[1]),
        .D  (r_vec[0]),
        .E1 (w_e1),
        .E2 (w_e2),
        .E3 (w_e3)
    );

    assign w_obs      = {Out_1, Out_2, Out_3};
    assign w_mismatch = (w_obs != {w_e1, w_e2, w_e3});
    assign w_settled  = (r_wait == 4'(SETTLE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next_state = ST_SETTLE;
            ST_SETTLE: if (w_settled) w_next_state = ST_CHECK;
            ST_CHECK:  w_next_state = (r_vec == VEC_LAST) ? ST_DONE : ST_SETTLE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Flags are decoded from the next state so the registered copies line up with r_state.
    always_comb begin
        w_busy_nxt = (w_next_state != ST_IDLE);
        w_done_nxt = (w_next_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec  <= '0;
            r_wait <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_err  <= '0;
            r_ffv  <= '0;
            r_ffo  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_vec  <= '0;
                        r_wait <= '0;
                        r_err  <= '0;
                        r_pass <= 1'b0;
                        r_ffv  <= '0;
                        r_ffo  <= '0;
                    end
                end
                ST_SETTLE: r_wait <= r_wait + 4'd1;
                ST_CHECK: begin
                    if (w_mismatch) begin
                        r_err <= r_err + 5'd1;
                        if (r_err == 5'd0) begin
                            r_ffv <= r_vec;
                            r_ffo <= w_obs;
                        end
                    end
                    if (r_vec != VEC_LAST) begin
                        r_vec  <= r_vec + 4'd1;
                        r_wait <= '0;
                    end
                end
                ST_DONE: r_pass <= (r_err == 5'd0);
                default: ;
            endcase
        end
    end

    assign {A, B, C, D}   = r_vec;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_fail_vec = r_ffv;
    assign first_fail_obs = r_ffo;

endmodule

// File: tb/tb_prob_3_34_sweeper.sv
// Bench for prob_3_34_sweeper: two instances (SETTLE=1 and SETTLE=3) against a faultable truth-table DUT.
// Expected sweep results are queued at start and checked by a monitor on each done pulse.
module tb_prob_3_34_sweeper;

    localparam int S1 = 1;
    localparam int S3 = 3;

    // Hand-derived {E1,E2,E3} for vec = {A,B,C,D} = 0..15
    localparam logic [2:0] TT [16] = '{3'b000, 3'b110, 3'b011, 3'b001,
                                       3'b000, 3'b010, 3'b010, 3'b011,
                                       3'b000, 3'b100, 3'b001, 3'b001,
                                       3'b000, 3'b111, 3'b010, 3'b011};

    typedef struct {
        int         due;
        logic [4:0] ec;
        logic       ps;
        logic [3:0] fv;
        logic [2:0] fo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st1 = 1'b0;
    logic st3 = 1'b0;
    int   fault = 0;
    logic sel = 1'b0;
    int   cyc = 0;

    int n_vec = 0;
    int n_bad = 0;
    exp_t sb[$];
    logic pass_pend = 1'b0;
    logic pass_exp  = 1'b0;

    logic a1, b1, c1, d1, o11, o12, o13, busy1, done1, pass1;
    logic [4:0] ec1;
    logic [3:0] fv1;
    logic [2:0] fo1;
    logic a3, b3, c3, d3, o31, o32, o33, busy3, done3, pass3;
    logic [4:0] ec3;
    logic [3:0] fv3;
    logic [2:0] fo3;

    logic [3:0] gv;
    logic g1, g2, g3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] resp(input logic [3:0] v, input int f);
        logic [2:0] r;
        r = TT[v];
        if (f == 1) r[2] = 1'b0;
        if (f == 2) r[0] = ~r[0];
        return r;
    endfunction

    assign {o11, o12, o13} = resp({a1, b1, c1, d1}, fault);
    assign {o31, o32, o33} = resp({a3, b3, c3, d3}, fault);

    prob_3_34_sweeper #(.SETTLE(S1)) dut1 (
        .clk(clk), .rst(rst), .start(st1),
        .A(a1), .B(b1), .C(c1), .D(d1),
        .Out_1(o11), .Out_2(o12), .Out_3(o13),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(ec1), .first_fail_vec(fv1), .first_fail_obs(fo1)
    );

    prob_3_34_sweeper #(.SETTLE(S3)) dut3 (
        .clk(clk), .rst(rst), .start(st3),
        .A(a3), .B(b3), .C(c3), .D(d3),
        .Out_1(o31), .Out_2(o32), .Out_3(o33),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_count(ec3), .first_fail_vec(fv3), .first_fail_obs(fo3)
    );

    prob_3_34_golden u_gold (
        .A(gv[3]), .B(gv[2]), .C(gv[1]), .D(gv[0]),
        .E1(g1), .E2(g2), .E3(g3)
    );

    logic       m_done, m_pass, m_busy;
    logic [4:0] m_ec;
    logic [3:0] m_fv, m_vec;
    logic [2:0] m_fo;
    assign m_done = sel ? done3 : done1;
    assign m_pass = sel ? pass3 : pass1;
    assign m_busy = sel ? busy3 : busy1;
    assign m_ec   = sel ? ec3 : ec1;
    assign m_fv   = sel ? fv3 : fv1;
    assign m_fo   = sel ? fo3 : fo1;
    assign m_vec  = sel ? {a3, b3, c3, d3} : {a1, b1, c1, d1};

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic kick(input int lat, input logic [4:0] ec, input logic ps,
                        input logic [3:0] fv, input logic [2:0] fo);
        exp_t e;
        @(negedge clk);
        if (sel) st3 = 1'b1; else st1 = 1'b1;
        e.due = cyc + lat;
        e.ec = ec; e.ps = ps; e.fv = fv; e.fo = fo;
        sb.push_back(e);
        @(negedge clk);
        st1 = 1'b0;
        st3 = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !pass_pend) return;
        end
        n_vec++;
        n_bad++;
        $display("FAIL sweep_timeout: got no done within %0d cycles, expected done", budget);
        sb.delete();
        pass_pend = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (pass_pend) begin
            check("pass", m_pass, pass_exp);
            pass_pend = 1'b0;
        end
        if (m_done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1, expected 0");
            end else begin
                e = sb.pop_front();
                check("done_latency", cyc, e.due);
                check("err_count", m_ec, e.ec);
                check("first_fail_vec", m_fv, e.fv);
                check("first_fail_obs", m_fo, e.fo);
                pass_exp  = e.ps;
                pass_pend = 1'b1;
            end
        end
    end

    // Hold-length monitor for the SETTLE=3 instance: SETTLE+1 cycles per vector, plus DONE on vec 15
    logic       pb = 1'b0;
    logic [3:0] pv = 4'd0;
    int         run = 0;
    always @(negedge clk) begin
        if (sel) begin
            if (busy3 && pb && {a3, b3, c3, d3} == pv) begin
                run++;
            end else begin
                if (pb) check("hold_len", run, (pv == 4'd15) ? S3 + 2 : S3 + 1);
                run = busy3 ? 1 : 0;
            end
            pb = busy3;
            pv = {a3, b3, c3, d3};
        end
    end

    initial begin
        int lat1, lat3;
        lat1 = 16 * (S1 + 1) + 1;
        lat3 = 16 * (S3 + 1) + 1;

        repeat (3) @(negedge clk);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_pass", pass1, 0);
        check("rst_err", ec1, 0);
        check("rst_ffv", fv1, 0);
        check("rst_ffo", fo1, 0);
        check("rst_abcd", {a1, b1, c1, d1}, 0);
        check("rst_busy3", busy3, 0);
        rst = 1'b0;

        for (int v = 0; v < 16; v++) begin
            gv = 4'(v);
            #1;
            check($sformatf("golden_vec%0d", v), {g1, g2, g3}, TT[v]);
        end

        // Clean sweep
        sel = 1'b0; fault = 0;
        kick(lat1, 5'd0, 1'b1, 4'd0, 3'b000);
        wait_idle(200);

        // Out_1 stuck-at-0
        fault = 1;
        kick(lat1, 5'd3, 1'b0, 4'd1, 3'b010);
        wait_idle(200);

        // Out_3 inverted, then results must hold in IDLE
        fault = 2;
        kick(lat1, 5'd16, 1'b0, 4'd0, 3'b001);
        wait_idle(200);
        repeat (10) @(negedge clk);
        check("hold_err", ec1, 16);
        check("hold_pass", pass1, 0);
        check("hold_ffv", fv1, 0);
        check("hold_ffo", fo1, 1);
        check("hold_busy", busy1, 0);

        // Reset during vec 7 CHECK aborts the sweep silently
        fault = 1;
        kick(lat1, 5'd0, 1'b0, 4'd0, 3'b000);
        begin
            int k;
            for (k = 0; k < 100; k++) begin
                @(negedge clk);
                if (busy1 && m_vec == 4'd7) break;
            end
            check("reach_vec7", k < 100, 1);
        end
        @(negedge clk);
        void'(sb.pop_front());
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy1, 0);
        check("abort_err", ec1, 0);
        check("abort_abcd", {a1, b1, c1, d1}, 0);
        check("abort_done", done1, 0);
        repeat (40) @(negedge clk);
        fault = 0;
        kick(lat1, 5'd0, 1'b1, 4'd0, 3'b000);
        wait_idle(200);

        // SETTLE=3 with a start re-pulse while busy
        sel = 1'b1;
        kick(lat3, 5'd0, 1'b1, 4'd0, 3'b000);
        repeat (10) @(negedge clk);
        st3 = 1'b1;
        @(negedge clk);
        st3 = 1'b0;
        wait_idle(300);
        repeat (20) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
